// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM controller. It zero-fills the RAM after reset, then serves
// one read or write request at a time.
// -----------------------------------------------------------------------------
// Module   : ram_ctrl
// Function : post-reset RAM clear sweep plus a request/response front end
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module ram_ctrl #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_rw,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD1  = 3'd3,
        RD2  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_t      state;
    // One bit wider than the address so the counter never aliases back to 0 mid-sweep.
    logic [AW:0] sweep_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            ram_addr    <= '0;
            ram_rw      <= 1'b0;
            ram_data_in <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            init_done   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                INIT: begin
                    // Terminal test uses the registered address, so the last write lands on this edge.
                    if (ram_rw && (ram_addr == LAST_ADDR)) begin
                        state     <= IDLE;
                        ram_rw    <= 1'b0;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        ram_rw      <= 1'b1;
                        ram_data_in <= '0;
                        ram_addr    <= sweep_cnt[AW-1:0];
                        sweep_cnt   <= sweep_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ram_addr    <= req_addr;
                        ram_rw      <= req_rw;
                        ram_data_in <= req_wdata;
                        req_ready   <= 1'b0;
                        state       <= req_rw ? WR : RD1;
                    end
                end
                WR: begin
                    ram_rw    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    resp_rdata <= ram_data_out;
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl wired to a behavioural registered-output RAM.
// -----------------------------------------------------------------------------
// Module   : tb_ram_ctrl
// Function : directed stimulus with hand-computed expectations
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_ram_ctrl;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_rw = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_fail = 0;
    int            nz_writes = 0;

    always #5 clk = ~clk;

    ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .init_done   (init_done),
        .ram_addr    (ram_addr),
        .ram_rw      (ram_rw),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // RAM is never reset: it acts on ram_rw at every edge and registers reads.
    always @(posedge clk) begin
        if (ram_rw) begin
            mem[ram_addr] <= ram_data_in;
            if (ram_data_in != '0 && !init_done) nz_writes <= nz_writes + 1;
        end else begin
            ram_data_out <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(resp_rdata), 32'd0);
        chk({tag, "_idone"}, 32'(init_done), 32'd0);
        chk({tag, "_raddr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_rrw"}, 32'(ram_rw), 32'd0);
        chk({tag, "_rdin"}, 32'(ram_data_in), 32'd0);
    endtask

    // Releases reset just after an edge, then checks the 8-edge zero sweep and init_done at edge 9.
    task automatic release_and_sweep(input string tag);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk({tag, "_sweep_rw"}, 32'(ram_rw), 32'd1);
            chk({tag, "_sweep_addr"}, 32'(ram_addr), 32'(i));
            chk({tag, "_sweep_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "_sweep_idone"}, 32'(init_done), 32'd0);
        end
        step();
        chk({tag, "_idone9"}, 32'(init_done), 32'd1);
        chk({tag, "_ready9"}, 32'(req_ready), 32'd1);
        chk({tag, "_rw9"}, 32'(ram_rw), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
        chk("wr_ready_low", 32'(req_ready), 32'd0);
        chk("wr_ram_rw", 32'(ram_rw), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'(a));
        chk("wr_ram_din", 32'(ram_data_in), 32'(d));
        step();
        chk("wr_ready_back", 32'(req_ready), 32'd1);
        chk("wr_no_resp", 32'(resp_valid), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0;
        chk("rd_ready_low", 32'(req_ready), 32'd0);
        step();
        chk("rd_no_resp_rd1", 32'(resp_valid), 32'd0);
        step();
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_resp_data", 32'(resp_rdata), 32'(exp));
        chk("rd_ready_back", 32'(req_ready), 32'd1);
        step();
        chk("rd_resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("rd_resp_hold", 32'(resp_rdata), 32'(exp));
    endtask

    initial begin
        // Reset state, then first clear sweep and read-back of all addresses.
        step(); step();
        check_reset_outputs("rst0");
        release_and_sweep("init1");
        for (int a = 0; a < 8; a++) do_read(AW'(a), 4'h0);

        do_write(3'd5, 4'hA);
        do_read(3'd5, 4'hA);

        // Back-to-back with req_valid held high the whole time.
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd3; req_wdata = 4'h7;
        step();
        chk("b2b_wr1_acc", 32'(req_ready), 32'd0);
        req_rw = 1'b0;
        step();
        chk("b2b_wr1_done", 32'(req_ready), 32'd1);
        step();
        chk("b2b_rd1_acc", 32'(req_ready), 32'd0);
        req_rw = 1'b1; req_wdata = 4'h2;
        step();
        chk("b2b_rd1_rd1", 32'(resp_valid), 32'd0);
        step();
        chk("b2b_rd1_valid", 32'(resp_valid), 32'd1);
        chk("b2b_rd1_data", 32'(resp_rdata), 32'h7);
        step();
        chk("b2b_pulse1_end", 32'(resp_valid), 32'd0);
        chk("b2b_wr2_acc", 32'(req_ready), 32'd0);
        chk("b2b_wr2_rw", 32'(ram_rw), 32'd1);
        chk("b2b_wr2_din", 32'(ram_data_in), 32'h2);
        req_rw = 1'b0;
        step();
        chk("b2b_wr2_done", 32'(req_ready), 32'd1);
        step();
        chk("b2b_rd2_acc", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        step();
        step();
        chk("b2b_rd2_valid", 32'(resp_valid), 32'd1);
        chk("b2b_rd2_data", 32'(resp_rdata), 32'h2);
        step();
        chk("b2b_pulse2_end", 32'(resp_valid), 32'd0);

        // Request held during INIT must wait for the first IDLE edge.
        reset = 1'b1;
        #1;
        check_reset_outputs("rst1");
        step();
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd4; req_wdata = 4'h9;
        release_and_sweep("init2");
        chk("init2_no_stray_wr", 32'(nz_writes), 32'd0);
        step();
        req_valid = 1'b0;
        chk("init2_acc_ready", 32'(req_ready), 32'd0);
        chk("init2_acc_rw", 32'(ram_rw), 32'd1);
        chk("init2_acc_addr", 32'(ram_addr), 32'd4);
        step();
        do_read(3'd4, 4'h9);
        do_read(3'd5, 4'h0);

        // Asynchronous reset during RD2 of a read of address 2.
        do_write(3'd2, 4'h5);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 3'd2;
        step();
        req_valid = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        step();
        chk("arst_no_pulse_a", 32'(resp_valid), 32'd0);
        step();
        chk("arst_no_pulse_b", 32'(resp_valid), 32'd0);
        release_and_sweep("init3");
        do_read(3'd2, 4'h0);

        // Boundary address.
        do_write(3'd7, 4'hF);
        do_read(3'd0, 4'h0);
        do_read(3'd7, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
